fp_row_packer: RTL and testbench
================================

# fp_row_packer

Writer side of the fingerprint row RAM. Takes the 8-bit grayscale pixel stream from the sensor front end, binarizes each pixel against a threshold, packs each 256-pixel line into one 256-bit word and writes it to the row RAM read by the display/search logic. Raises `test_done` once a full frame is stored; the search state machine starts on its rising edge.

## Interface
- `ROW_PIX`, 256: pixels per row; also the RAM word width.
- `ROWS`, 288: rows per frame.
- `ADDR_W`, 9: RAM address width; must satisfy 2^ADDR_W ≥ ROWS.
- `THRES_DEF`, 8'd128: threshold used when `thres_in` is 0.

Ports:
- `sensor_clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `pix_sof` in 1: start of frame, qualified by `pix_valid`; marks pixel (0,0).
- `pix_valid` in 1: pixel strobe; no backpressure.
- `pix_data` in 8: grayscale value, dark = ridge.
- `thres_in` in 8: binarization threshold, latched at SOF.
- `ram_we` out 1: one-cycle write strobe.
- `ram_addr` out ADDR_W: row index being written.
- `ram_data` out ROW_PIX: packed row; bit x = pixel x.
- `test_done` out 1: high from the last row write until the next accepted SOF.
- `busy` out 1: high while a frame is being filled.
- `ridge_cnt` out 18: count of ridge pixels in the last completed frame.
- `frame_err` out 1: sticky until the next SOF; set when a frame is aborted by an early SOF.

## Operation
- Binarize: bit = (`pix_data` < thr) ? 1 : 0.
  - thr = `thres_in` latched on the SOF pixel, or `THRES_DEF` if the latched value is 0.
  - The SOF pixel itself uses the newly latched thr.
- State machine:
  - IDLE: pixels without SOF are ignored. An accepted SOF pixel goes to FILL, with x=1 and y=0 after that pixel.
  - FILL: each accepted pixel sets `row_buf[x]` and increments x.
    - On pixel x = ROW_PIX−1, the row is complete: issue the write, clear `row_buf`, x←0, y←y+1.
    - When the completed row is y = ROWS−1, go to DONE.
  - DONE: `test_done`=1; non-SOF pixels are ignored; an accepted SOF restarts exactly as from IDLE.
- Write data: `ram_data` = `row_buf` with the final pixel's bit merged in at index ROW_PIX−1. `ram_addr` = y of the completed row.
- Ridge counting: an internal counter accumulates ridge bits during FILL. It is copied to `ridge_cnt` on the final row write and cleared on SOF. `ridge_cnt` holds its value across later frames until the next completion.
- SOF while in FILL:
  - Abort the partial frame; the partial row is not written.
  - Set `frame_err` and restart at (0,0) with the SOF pixel.
  - Rows already written stay in RAM.
- `test_done` clears in the same cycle an SOF is accepted, so a new rising edge occurs per frame.
- Counter widths: x is log2(ROW_PIX) bits and y is ADDR_W bits. Neither wraps past its limit because the terminal conditions are checked first.

## Timing
- Reset values:
  - Outputs: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `test_done`=0, `busy`=0, `ridge_cnt`=0, `frame_err`=0.
  - Internal: state IDLE, x=y=0, `row_buf`=0.
- All outputs are registered.
- Write latency: `ram_we` is high on the cycle after the clock edge that accepted the last pixel of a row, for exactly one cycle.
- Back-to-back writes: a pixel accepted in the same cycle `ram_we` is high lands in the cleared `row_buf` (no lost pixel). Full-rate `pix_valid` is supported.
- `test_done` and `busy`=0 assert on the same cycle as the final `ram_we`.
- `busy` rises on the cycle after SOF acceptance.
- Reset mid-frame: all state returns to reset values immediately, with no write issued. The next frame requires an SOF.

## Structure
- Shared package `fp_pkg`:
  - `FP_ROW_PIX`=256, `FP_ROWS`=288, `FP_ADDR_W`=9.
  - State enum (IDLE, FILL, DONE).
  - Also used by the display/search block for its RAM address widths.
- Sub-module `fp_binarize`: combinational compare plus the threshold latch with the zero→default substitution.
- Everything else stays in `fp_row_packer`.

## Test plan
- Full frame at full rate: 288×256 pixels, alternating 0x10/0xF0, `thres_in`=0x80.
  - 288 writes, addr 0..287, each `ram_data` = 0x5555…55 (even bits 1).
  - `test_done` rises with the 288th write.
  - `ridge_cnt`=36864.
- Threshold default: `thres_in`=0, all pixels 0x7F → every word all-ones, `ridge_cnt`=73728. Repeat with pixel 0x80 → all-zero words, `ridge_cnt`=0.
- Gapped valid: `pix_valid` random 30% duty, single row check.
  - Pixel 0 = 0x00 and pixel 255 = 0x00, all others 0xFF.
  - Word 0 = bit0 | bit255 set only.
- Early SOF: SOF again after 3 rows + 100 pixels.
  - Exactly 3 writes before the restart and no partial write.
  - `frame_err`=1; the new frame then completes normally at addresses 0..287.
- Pixels before SOF / in DONE: 500 non-SOF pixels → no `ram_we`, `busy` stays 0, `test_done` stays as is.
- Reset at row 10 mid-row: outputs return to 0 asynchronously; a subsequent frame writes a correct row 0 first.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and state type for the fingerprint row RAM writer and its readers.
package fp_pkg;

  localparam int unsigned FP_ROW_PIX = 256;
  localparam int unsigned FP_ROWS    = 288;
  localparam int unsigned FP_ADDR_W  = 9;
  localparam int unsigned FP_PIX_W   = 8;
  localparam int unsigned FP_CNT_W   = 18;

  localparam logic [FP_PIX_W-1:0] FP_THRES_DEF = 8'd128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fp_state_e;

endpackage

// File: rtl/fp_binarize.sv
// Pixel binarizer: threshold latched on SOF (zero selects the default), dark pixels become ridge bits.
module fp_binarize
  import fp_pkg::*;
#(
  parameter logic [FP_PIX_W-1:0] THRES_DEF = FP_THRES_DEF
) (
  input  logic                sensor_clk,
  input  logic                rst_n,
  input  logic                sof_load,
  input  logic [FP_PIX_W-1:0] thres_in,
  input  logic [FP_PIX_W-1:0] pix_data,
  output logic                ridge_c
);

  logic [FP_PIX_W-1:0] thr_q;
  logic [FP_PIX_W-1:0] thr_new_c;
  logic [FP_PIX_W-1:0] thr_eff_c;

  // The SOF pixel is compared against the threshold being latched on that same cycle.
  assign thr_new_c = (thres_in == '0) ? THRES_DEF : thres_in;
  assign thr_eff_c = sof_load ? thr_new_c : thr_q;
  assign ridge_c   = (pix_data < thr_eff_c);

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= THRES_DEF;
    end else if (sof_load) begin
      thr_q <= thr_new_c;
    end
  end

endmodule

// File: rtl/fp_row_packer.sv
// Packs binarized sensor pixels into one RAM word per row and flags frame completion for the search logic.
module fp_row_packer
  import fp_pkg::*;
#(
  parameter int unsigned         ROW_PIX   = FP_ROW_PIX,
  parameter int unsigned         ROWS      = FP_ROWS,
  parameter int unsigned         ADDR_W    = FP_ADDR_W,
  parameter logic [FP_PIX_W-1:0] THRES_DEF = FP_THRES_DEF
) (
  input  logic                sensor_clk,
  input  logic                rst_n,
  input  logic                pix_sof,
  input  logic                pix_valid,
  input  logic [FP_PIX_W-1:0] pix_data,
  input  logic [FP_PIX_W-1:0] thres_in,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [ROW_PIX-1:0]  ram_data,
  output logic                test_done,
  output logic                busy,
  output logic [FP_CNT_W-1:0] ridge_cnt,
  output logic                frame_err
);

  localparam int unsigned       X_W    = $clog2(ROW_PIX);
  localparam logic [X_W-1:0]    X_LAST = X_W'(ROW_PIX - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(ROWS - 1);

  fp_state_e            state_q, state_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [ADDR_W-1:0]    y_q, y_d;
  logic [ROW_PIX-1:0]   row_buf_q, row_buf_d;
  logic [FP_CNT_W-1:0]  cnt_q, cnt_d;

  logic                 we_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [ROW_PIX-1:0]   data_d;
  logic                 done_d;
  logic                 busy_d;
  logic [FP_CNT_W-1:0]  ridge_cnt_d;
  logic                 err_d;

  logic                 sof_c;
  logic                 ridge_c;

  assign sof_c = pix_valid & pix_sof;

  fp_binarize #(
    .THRES_DEF (THRES_DEF)
  ) u_binarize (
    .sensor_clk (sensor_clk),
    .rst_n      (rst_n),
    .sof_load   (sof_c),
    .thres_in   (thres_in),
    .pix_data   (pix_data),
    .ridge_c    (ridge_c)
  );

  // State and datapath registers.
  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      row_buf_q <= '0;
      cnt_q     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      test_done <= 1'b0;
      busy      <= 1'b0;
      ridge_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_buf_q <= row_buf_d;
      cnt_q     <= cnt_d;
      ram_we    <= we_d;
      ram_addr  <= addr_d;
      ram_data  <= data_d;
      test_done <= done_d;
      busy      <= busy_d;
      ridge_cnt <= ridge_cnt_d;
      frame_err <= err_d;
    end
  end

  // Next-state: an accepted SOF restarts from any state; otherwise only FILL consumes pixels.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_buf_d   = row_buf_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    addr_d      = ram_addr;
    data_d      = ram_data;
    done_d      = test_done;
    busy_d      = busy;
    ridge_cnt_d = ridge_cnt;
    err_d       = frame_err;

    if (sof_c) begin
      err_d        = (state_q == FILL);
      state_d      = FILL;
      x_d          = X_W'(1);
      y_d          = '0;
      row_buf_d    = '0;
      row_buf_d[0] = ridge_c;
      cnt_d        = FP_CNT_W'(ridge_c);
      done_d       = 1'b0;
      busy_d       = 1'b1;
    end else if (pix_valid && (state_q == FILL)) begin
      cnt_d = cnt_q + FP_CNT_W'(ridge_c);
      if (x_q == X_LAST) begin
        // Last pixel bypasses row_buf so the next row can start on the following cycle.
        we_d                = 1'b1;
        addr_d              = y_q;
        data_d              = row_buf_q;
        data_d[ROW_PIX-1]   = ridge_c;
        row_buf_d           = '0;
        x_d                 = '0;
        if (y_q == Y_LAST) begin
          state_d     = DONE;
          y_d         = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          ridge_cnt_d = cnt_d;
        end else begin
          y_d = y_q + ADDR_W'(1);
        end
      end else begin
        row_buf_d[x_q] = ridge_c;
        x_d            = x_q + X_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_row_packer.sv
// Scoreboard bench for fp_row_packer; frame height is shortened so several whole frames fit a short run.
module tb_fp_row_packer;
  import fp_pkg::*;

  localparam int unsigned ROW_PIX = 256;
  localparam int unsigned ROWS    = 12;
  localparam int unsigned ADDR_W  = 9;

  logic               sensor_clk;
  logic               rst_n;
  logic               pix_sof;
  logic               pix_valid;
  logic [7:0]         pix_data;
  logic [7:0]         thres_in;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [ROW_PIX-1:0] ram_data;
  logic               test_done;
  logic               busy;
  logic [17:0]        ridge_cnt;
  logic               frame_err;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [ROW_PIX-1:0] data;
    logic               last;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  int          wr_count;
  int unsigned exp_ridge;

  fp_row_packer #(
    .ROW_PIX   (ROW_PIX),
    .ROWS      (ROWS),
    .ADDR_W    (ADDR_W),
    .THRES_DEF (8'd128)
  ) dut (
    .sensor_clk (sensor_clk),
    .rst_n      (rst_n),
    .pix_sof    (pix_sof),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .thres_in   (thres_in),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .test_done  (test_done),
    .busy       (busy),
    .ridge_cnt  (ridge_cnt),
    .frame_err  (frame_err)
  );

  initial sensor_clk = 1'b0;
  always #5 sensor_clk = ~sensor_clk;

  // Every RAM write is matched against the oldest expected row, including done/busy timing.
  always @(negedge sensor_clk) begin
    if (rst_n && ram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d", ram_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        wr_count++;
        if (ram_addr !== e.addr || ram_data !== e.data) begin
          failures++;
          $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h", ram_addr, ram_data, e.addr, e.data);
        end
        checks++;
        if (test_done !== e.last || busy !== !e.last) begin
          failures++;
          $display("FAIL done_timing addr=%0d test_done=%b busy=%b expected test_done=%b busy=%b",
                   ram_addr, test_done, busy, e.last, !e.last);
        end
      end
    end
  end

  function automatic logic [7:0] pix_val(input int kind, input int x);
    case (kind)
      0:       return (x % 2 == 0) ? 8'h10 : 8'hF0;
      1:       return 8'h7F;
      2:       return 8'h80;
      default: return (x == 0 || x == int'(ROW_PIX) - 1) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  task automatic send(input logic sof, input logic [7:0] d);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    @(posedge sensor_clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sensor_clk);
    #1;
  endtask

  // Drives nrows full rows plus npart pixels of one more row; expected words are pushed as rows complete.
  task automatic run_frame(input logic [7:0] thr, input int kind, input int nrows, input int npart,
                           input bit gapped, input logic exp_err);
    logic [7:0]         eff;
    logic [7:0]         d;
    logic               b;
    logic [ROW_PIX-1:0] row;
    int                 ridge;
    exp_t               e;
    eff   = (thr == 8'h00) ? 8'd128 : thr;
    ridge = 0;
    for (int y = 0; y < nrows + ((npart > 0) ? 1 : 0); y++) begin
      row = '0;
      for (int x = 0; x < int'(ROW_PIX); x++) begin
        if (y == nrows && x == npart) break;
        d      = pix_val(kind, x);
        b      = (d < eff);
        row[x] = b;
        ridge += int'(b);
        if (gapped) begin
          while ($urandom_range(0, 99) >= 30) idle(1);
        end
        if (x == int'(ROW_PIX) - 1) begin
          e.addr = ADDR_W'(y);
          e.data = row;
          e.last = (y == int'(ROWS) - 1);
          exp_q.push_back(e);
        end
        if (y == 0 && x == 0) begin
          thres_in = thr;
          send(1'b1, d);
          thres_in = 8'h01;
          checks++;
          if (busy !== 1'b1 || test_done !== 1'b0) begin
            failures++;
            $display("FAIL sof_accept busy=%b test_done=%b expected busy=1 test_done=0", busy, test_done);
          end
          checks++;
          if (frame_err !== exp_err) begin
            failures++;
            $display("FAIL sof_frame_err frame_err=%b expected %b", frame_err, exp_err);
          end
        end else begin
          send(1'b0, d);
        end
      end
    end
    if (nrows == int'(ROWS)) exp_ridge = ridge;
  endtask

  task automatic drain_and_check_frame(input string name);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes_missing pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (ridge_cnt !== 18'(exp_ridge) || test_done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end ridge_cnt=%0d test_done=%b busy=%b expected ridge_cnt=%0d test_done=1 busy=0",
               name, ridge_cnt, test_done, busy, exp_ridge);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    pix_sof   = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    thres_in  = 8'h00;
    idle(3);
    checks++;
    if ({ram_we, test_done, busy, frame_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags we/done/busy/err=%b expected 0000", {ram_we, test_done, busy, frame_err});
    end
    checks++;
    if (ram_addr !== '0 || ram_data !== '0 || ridge_cnt !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%0d data=%h ridge_cnt=%0d expected all 0", ram_addr, ram_data, ridge_cnt);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_pre_sof();
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 500; i++) send(1'b0, 8'h00);
    idle(2);
    checks++;
    if (busy !== 1'b0 || test_done !== 1'b0 || wr_count != w0) begin
      failures++;
      $display("FAIL pre_sof busy=%b test_done=%b writes=%0d expected busy=0 test_done=0 writes=0",
               busy, test_done, wr_count - w0);
    end
  endtask

  task automatic test_full_rate();
    run_frame(8'h80, 0, ROWS, 0, 1'b0, 1'b0);
    drain_and_check_frame("full_rate");
    idle(3);
  endtask

  task automatic test_thres_default();
    run_frame(8'h00, 1, ROWS, 0, 1'b0, 1'b0);
    drain_and_check_frame("thres_default_7f");
    idle(3);
    run_frame(8'h00, 2, ROWS, 0, 1'b0, 1'b0);
    drain_and_check_frame("thres_default_80");
    idle(3);
  endtask

  task automatic test_gapped();
    run_frame(8'h80, 3, ROWS, 0, 1'b1, 1'b0);
    drain_and_check_frame("gapped");
    idle(3);
  endtask

  task automatic test_early_sof();
    int w0;
    w0 = wr_count;
    run_frame(8'h80, 0, 3, 100, 1'b0, 1'b0);
    idle(2);
    checks++;
    if (wr_count - w0 != 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL early_sof_partial writes=%0d pending=%0d expected writes=3 pending=0",
               wr_count - w0, exp_q.size());
    end
    run_frame(8'h80, 0, ROWS, 0, 1'b0, 1'b1);
    drain_and_check_frame("early_sof_restart");
    checks++;
    if (frame_err !== 1'b1 || wr_count - w0 != 3 + int'(ROWS)) begin
      failures++;
      $display("FAIL early_sof_err frame_err=%b writes=%0d expected frame_err=1 writes=%0d",
               frame_err, wr_count - w0, 3 + ROWS);
    end
  endtask

  task automatic test_done_ignore();
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 500; i++) send(1'b0, pix_val(0, i));
    idle(2);
    checks++;
    if (test_done !== 1'b1 || busy !== 1'b0 || frame_err !== 1'b1 || wr_count != w0) begin
      failures++;
      $display("FAIL done_ignore test_done=%b busy=%b frame_err=%b writes=%0d expected 1 0 1 0",
               test_done, busy, frame_err, wr_count - w0);
    end
  endtask

  task automatic test_reset_mid();
    run_frame(8'h80, 0, 10, 50, 1'b0, 1'b0);
    @(posedge sensor_clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, test_done, busy, frame_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_flags we/done/busy/err=%b expected 0000", {ram_we, test_done, busy, frame_err});
    end
    checks++;
    if (ram_addr !== '0 || ram_data !== '0 || ridge_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_data addr=%0d data=%h ridge_cnt=%0d expected all 0", ram_addr, ram_data, ridge_cnt);
    end
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) send(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_needs_sof busy=%b expected 0", busy);
    end
    run_frame(8'h00, 1, ROWS, 0, 1'b0, 1'b0);
    drain_and_check_frame("after_reset");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    wr_count  = 0;
    exp_ridge = 0;
    test_reset();
    test_pre_sof();
    test_full_rate();
    test_thres_default();
    test_gapped();
    test_early_sof();
    test_done_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
